// File: rtl/hdu_pkg.sv
// Shared constants and helpers for the fallback path (arbiter and fallback FIFO).
package hdu_pkg;

  localparam int FALLBACK_FIFO_DEPTH = 4;
  localparam int FUNC_ID_WIDTH       = 16;
  localparam int TOKEN_WIDTH         = 16;

  // Entry pushed into the fallback FIFO.
  typedef struct packed {
    logic [FUNC_ID_WIDTH-1:0] func_id;
    logic [TOKEN_WIDTH-1:0]   token;
  } fb_entry_t;

  // clog2 that never returns 0, so index/pointer vectors are at least 1 bit wide.
  function automatic int safe_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping) wins.
module rr_arbiter
  import hdu_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = safe_clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/fallback_arbiter.sv
// Credit-gated round-robin arbiter feeding the fallback FIFO, with telemetry counters.
module fallback_arbiter
  import hdu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CREDITS = FALLBACK_FIFO_DEPTH,
  parameter int CW      = $clog2(CREDITS) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_enable,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][FUNC_ID_WIDTH-1:0]  req_func_id,
  input  logic [NUM_REQ-1:0][TOKEN_WIDTH-1:0]    req_token,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   fail_valid,
  output logic [FUNC_ID_WIDTH-1:0]               fail_func_id,
  output logic [TOKEN_WIDTH-1:0]                 fail_token,
  input  logic                                   bridge_pop,
  output logic [CW-1:0]                          credits,
  output logic [31:0]                            cnt_grants,
  output logic [31:0]                            cnt_stall,
  output logic                                   err_underflow
);

  localparam int          PW       = safe_clog2(NUM_REQ);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [CW-1:0]      credits_q, credits_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               fail_valid_q, fail_valid_d;
  fb_entry_t          fail_q, fail_d;
  logic [31:0]        cnt_grants_q, cnt_grants_d;
  logic [31:0]        cnt_stall_q, cnt_stall_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               grant_fire;
  logic               stall;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_gnt),
    .index (arb_idx)
  );

  // Eligibility looks only at registered credits; a same-cycle pop cannot unblock a grant.
  assign grant_fire = !rst && cfg_enable && (credits_q != '0) && (|req_valid);
  assign req_ready  = grant_fire ? arb_gnt : '0;
  assign stall      = (|req_valid) && (credits_q == '0);

  always_comb begin
    credits_d = credits_q;
    if (grant_fire && !bridge_pop)
      credits_d = credits_q - CW'(1);
    else if (!grant_fire && bridge_pop && credits_q != CRED_MAX)
      credits_d = credits_q + CW'(1);

    err_d = err_q | (bridge_pop && credits_q == CRED_MAX);

    rr_ptr_d = rr_ptr_q;
    if (grant_fire)
      rr_ptr_d = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);

    fail_valid_d = grant_fire;
    fail_d       = fail_q;
    if (grant_fire) begin
      fail_d.func_id = req_func_id[arb_idx];
      fail_d.token   = req_token[arb_idx];
    end

    cnt_grants_d = cnt_grants_q;
    if (grant_fire && cnt_grants_q != '1)
      cnt_grants_d = cnt_grants_q + 32'd1;

    cnt_stall_d = cnt_stall_q;
    if (stall && cnt_stall_q != '1)
      cnt_stall_d = cnt_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q    <= CRED_MAX;
      rr_ptr_q     <= '0;
      fail_valid_q <= 1'b0;
      fail_q       <= '0;
      cnt_grants_q <= '0;
      cnt_stall_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      rr_ptr_q     <= rr_ptr_d;
      fail_valid_q <= fail_valid_d;
      fail_q       <= fail_d;
      cnt_grants_q <= cnt_grants_d;
      cnt_stall_q  <= cnt_stall_d;
      err_q        <= err_d;
    end
  end

  assign credits       = credits_q;
  assign fail_valid    = fail_valid_q;
  assign fail_func_id  = fail_q.func_id;
  assign fail_token    = fail_q.token;
  assign cnt_grants    = cnt_grants_q;
  assign cnt_stall     = cnt_stall_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fallback_arbiter.sv
// Scoreboarded bench for fallback_arbiter: directed corner cases then randomized traffic.
module tb_fallback_arbiter;
  import hdu_pkg::*;

  localparam int N  = 4;
  localparam int CR = FALLBACK_FIFO_DEPTH;
  localparam int FW = FUNC_ID_WIDTH;
  localparam int TW = TOKEN_WIDTH;
  localparam int CW = $clog2(CR) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cfg_enable = 1'b0;
  logic                  bridge_pop = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0][FW-1:0]  req_func_id = '0;
  logic [N-1:0][TW-1:0]  req_token = '0;
  logic [N-1:0]          req_ready;
  logic                  fail_valid;
  logic [FW-1:0]         fail_func_id;
  logic [TW-1:0]         fail_token;
  logic [CW-1:0]         credits;
  logic [31:0]           cnt_grants, cnt_stall;
  logic                  err_underflow;

  fallback_arbiter #(.NUM_REQ(N), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_func_id(req_func_id), .req_token(req_token),
    .req_ready(req_ready), .fail_valid(fail_valid), .fail_func_id(fail_func_id),
    .fail_token(fail_token), .bridge_pop(bridge_pop), .credits(credits),
    .cnt_grants(cnt_grants), .cnt_stall(cnt_stall), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] f;
    logic [TW-1:0] t;
    int            due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  // Reference state, expressed directly from the arbitration/credit rules.
  int   m_cred = CR;
  int   m_ptr = 0;
  int   m_grants = 0;
  int   m_stall = 0;
  bit   m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every fail_valid must match the oldest outstanding grant, on time.
  always @(negedge clk) begin
    if (fail_valid) begin
      if (sbq.size() == 0 || sbq[0].due != cyc) begin
        compared++;
        mismatched++;
        $display("FAIL fail_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("fail_func_id", 64'(fail_func_id), 64'(mon_e.f));
        chk("fail_token", 64'(fail_token), 64'(mon_e.t));
      end
    end else if (sbq.size() != 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL fail_valid_missing: got 0 expected 1 (cycle %0d)", cyc);
    end
  end

  // One clock cycle: apply inputs after negedge, check outputs, advance the reference.
  task automatic step(input bit r, input bit e, input bit p, input logic [N-1:0] v,
                      input logic [N-1:0][FW-1:0] f, input logic [N-1:0][TW-1:0] t);
    int           g;
    logic [N-1:0] er;
    @(negedge clk);
    rst = r; cfg_enable = e; bridge_pop = p; req_valid = v; req_func_id = f; req_token = t;
    #1;
    g = -1;
    if (!r && e && m_cred != 0) begin
      for (int k = 0; k < N; k++) begin
        if (v[(m_ptr + k) % N]) begin
          g = (m_ptr + k) % N;
          break;
        end
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("credits", 64'(credits), 64'(m_cred));
    chk("cnt_grants", 64'(cnt_grants), 64'(m_grants));
    chk("cnt_stall", 64'(cnt_stall), 64'(m_stall));
    chk("err_underflow", 64'(err_underflow), 64'(m_err));
    if (g >= 0) sbq.push_back('{f[g], t[g], cyc + 1});
    if (r) begin
      m_cred = CR; m_ptr = 0; m_grants = 0; m_stall = 0; m_err = 1'b0;
    end else begin
      if (|v && m_cred == 0) m_stall++;
      if (p && m_cred == CR) m_err = 1'b1;
      if (g >= 0) begin
        m_grants++;
        m_ptr = (g + 1) % N;
      end
      if (g >= 0 && !p) m_cred--;
      else if (g < 0 && p && m_cred < CR) m_cred++;
    end
  endtask

  logic [N-1:0][FW-1:0] fr;
  logic [N-1:0][TW-1:0] tr;

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      fr[i] = FW'($urandom);
      tr[i] = TW'($urandom);
    end
  endtask

  initial begin
    logic [N-1:0] ek;
    randomize_payload();
    step(1, 1, 0, '0, fr, tr);
    step(1, 1, 0, '0, fr, tr);

    // Four requesters drain all credits in order, then stall.
    for (int k = 0; k < 4; k++) begin
      randomize_payload();
      step(0, 1, 0, 4'b1111, fr, tr);
      ek = '0; ek[k] = 1'b1;
      chk("seq_grant", 64'(req_ready), 64'(ek));
    end
    step(0, 1, 0, 4'b1111, fr, tr);
    chk("drained_credits", 64'(credits), 64'd0);
    chk("drained_ready", 64'(req_ready), 64'd0);
    step(0, 1, 0, 4'b1111, fr, tr);
    chk("stall_count", 64'(cnt_stall), 64'd1);

    // Pop and request at zero credits: grant only on the following cycle.
    step(0, 1, 1, 4'b0100, fr, tr);
    chk("pop_no_grant", 64'(req_ready), 64'd0);
    step(0, 1, 0, 4'b0100, fr, tr);
    chk("pop_then_grant", 64'(req_ready), 64'b0100);
    step(0, 1, 0, '0, fr, tr);
    chk("pop_grant_credits", 64'(credits), 64'd0);

    // Grant and pop together at two credits.
    step(0, 1, 1, '0, fr, tr);
    step(0, 1, 1, '0, fr, tr);
    fr[0] = 16'h00A5;
    step(0, 1, 1, 4'b0001, fr, tr);
    chk("credits_before_both", 64'(credits), 64'd2);
    step(0, 1, 0, '0, fr, tr);
    chk("credits_after_both", 64'(credits), 64'd2);
    chk("fail_func_a5", 64'(fail_func_id), 64'h00A5);

    // Underflow is sticky until reset.
    step(1, 1, 0, '0, fr, tr);
    step(0, 1, 1, '0, fr, tr);
    step(0, 1, 0, '0, fr, tr);
    chk("underflow_set", 64'(err_underflow), 64'd1);
    chk("underflow_credits", 64'(credits), 64'd4);
    for (int k = 0; k < 3; k++) step(0, 1, 0, '0, fr, tr);
    chk("underflow_sticky", 64'(err_underflow), 64'd1);
    step(1, 1, 0, '0, fr, tr);
    step(0, 1, 0, '0, fr, tr);
    chk("underflow_cleared", 64'(err_underflow), 64'd0);

    // Round-robin wrap from pointer 3.
    step(0, 1, 0, 4'b0100, fr, tr);
    step(0, 1, 0, 4'b1001, fr, tr);
    chk("rr_wrap_3", 64'(req_ready), 64'b1000);
    step(0, 1, 0, 4'b1001, fr, tr);
    chk("rr_wrap_0", 64'(req_ready), 64'b0001);

    // Disabled arbiter issues nothing.
    step(1, 1, 0, '0, fr, tr);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 4'b0010, fr, tr);
    step(0, 0, 0, '0, fr, tr);
    chk("disabled_grants", 64'(cnt_grants), 64'd0);
    chk("disabled_credits", 64'(credits), 64'd4);
    chk("disabled_stall", 64'(cnt_stall), 64'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      randomize_payload();
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) == 0, N'($urandom), fr, tr);
    end
    step(0, 1, 0, '0, fr, tr);
    step(0, 1, 0, '0, fr, tr);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fallback_arbiter.md
FALLBACK_ARBITER -- requirements
Module: fallback_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of fallback requesters (range 2..8).
REQ-002 Parameter CREDITS, default hdu_pkg::FALLBACK_FIFO_DEPTH (4), downstream fallback FIFO slots.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_enable  in  1  when low, no new grants are issued.
REQ-006 req_valid  in  NUM_REQ  per-requester fallback request.
REQ-007 req_func_id  in  NUM_REQ x FUNC_ID_WIDTH  per-requester function ID.
REQ-008 req_token  in  NUM_REQ x TOKEN_WIDTH  per-requester token.
REQ-009 req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i].
REQ-010 fail_valid  out  1  single-cycle push into fallback FIFO.
REQ-011 fail_func_id  out  FUNC_ID_WIDTH  function ID of pushed entry.
REQ-012 fail_token  out  TOKEN_WIDTH  token of pushed entry.
REQ-013 bridge_pop  in  1  pulse per FIFO entry consumed by host (host_ready && irq_valid).
REQ-014 credits  out  clog2(CREDITS)+1  free downstream slots.
REQ-015 cnt_grants  out  32  saturating count of accepted requests.
REQ-016 cnt_stall  out  32  saturating count of cycles with any req_valid but zero credits.
REQ-017 err_underflow  out  1  sticky: bridge_pop seen while credits == CREDITS.

Function
REQ-018 req_ready is combinational from registered state and req_valid; at most one bit high per cycle.
REQ-019 Grant only when cfg_enable && credits != 0 && |req_valid; otherwise req_ready = 0.
REQ-020 Arbitration: round-robin, search starts at rr_ptr, first i (mod NUM_REQ) with req_valid[i] wins.
REQ-021 After grant to i, rr_ptr <= (i+1) mod NUM_REQ; rr_ptr unchanged on cycles without grant.
REQ-022 Grant in cycle t -> fail_valid = 1 in cycle t+1 only, with func_id/token captured at t.
REQ-023 fail_valid deasserts in t+1 if no grant at t; fail_func_id/fail_token hold last value when idle.
REQ-024 Back-to-back grants allowed every cycle while credits remain; fail_valid may stay high consecutive cycles.
REQ-025 Credit update: grant only -> credits-1; bridge_pop only -> credits+1; both same cycle -> unchanged.
REQ-026 Grant eligibility uses registered credits; a same-cycle bridge_pop does not enable a grant when credits == 0.
REQ-027 bridge_pop while credits == CREDITS: credits unchanged, err_underflow <= 1 (sticky until reset).
REQ-028 credits never exceeds CREDITS nor goes below 0; therefore fallback FIFO never overflows.
REQ-029 cnt_grants +1 per grant, cnt_stall +1 per qualifying cycle; both saturate at 32'hFFFFFFFF.
REQ-030 cfg_enable deassert mid-stream: pending fail_valid from prior grant still issues; credits still track pops.
REQ-031 Requester dropping req_valid without grant is legal; no state change for it.

Reset
REQ-032 On rst: credits = CREDITS, rr_ptr = 0, fail_valid = 0, fail_func_id = 0, fail_token = 0.
REQ-033 On rst: cnt_grants = 0, cnt_stall = 0, err_underflow = 0; req_ready = 0 during reset cycle.
REQ-034 Reset mid-operation discards any grant in flight; downstream FIFO is reset on the same rst in system.

Structure
REQ-035 FALLBACK_FIFO_DEPTH, FUNC_ID_WIDTH, TOKEN_WIDTH and safe_clog2 reside in hdu_pkg, shared with the fallback FIFO.
REQ-036 Round-robin selection implemented as one sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, index).
REQ-037 Credit counter, capture register and telemetry counters reside in fallback_arbiter.

Verification
REQ-038 Reset, all req_valid=4'b1111, no pops -> grants to 0,1,2,3 in consecutive cycles, credits 4->0, then req_ready=0, cnt_stall increments.
REQ-039 credits=0, bridge_pop and req_valid[2] same cycle -> no grant that cycle, grant to 2 next cycle, credits ends 0.
REQ-040 credits=2, grant and bridge_pop same cycle -> credits stays 2; fail_valid next cycle with granted func_id 0x00A5.
REQ-041 After reset, bridge_pop with credits=4 -> err_underflow=1, credits=4, remains 1 until rst.
REQ-042 rr_ptr=3, req_valid=4'b1001 -> grant 3; next cycle with same requests -> grant 0.
REQ-043 cfg_enable=0, req_valid=4'b0010 for 10 cycles -> no grants, cnt_grants=0, credits=4, cnt_stall=0.
